// File: rtl/bram_pkg.sv
// bram_pkg: shared helpers for the BRAM client-port controllers.
//   bram_latency      read latency of the BRAM port (1 + PIPELINED)
//   bram_credit_width width of a counter that must hold 0..depth
//   bram_widths_ok    data width equals CHUNKSIZE * WE_WIDTH
//   bram_depth_ok     response FIFO has at least one entry
//   bram_full_rate    depth is enough to sustain one request per cycle
package bram_pkg;

    function automatic int bram_latency(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

    function automatic int bram_credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit bram_widths_ok(input int data_width, input int chunksize,
                                          input int we_width);
        return data_width == chunksize * we_width;
    endfunction

    function automatic bit bram_depth_ok(input int depth);
        return depth >= 1;
    endfunction

    // Depth must cover the read latency, the output register and the one-cycle
    // delay before a freed credit shows up in REQ_READY.
    function automatic bit bram_full_rate(input int depth, input int pipelined);
        return depth >= bram_latency(pipelined) + 2;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// bram_rsp_fifo: response queue for bram_server_port.
//   clk, rst   clock, asynchronous active-high reset (pointers and count only)
//   push       write push_data this cycle
//   pop        drop the head entry this cycle (ignored when empty)
//   pop_data   head entry, valid whenever empty == 0
//   full/empty occupancy flags
// Any depth >= 1 is supported; pointers wrap explicitly at DEPTH-1.
module bram_rsp_fifo
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = bram_credit_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_next(wr_ptr);
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and is never reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bram_server_port.sv
// bram_server_port: client-side controller for one port of a byte-enable BRAM.
//   CLK, RST            port clock, asynchronous active-high reset
//   REQ_VALID/READY     request handshake; REQ_WE all-zero = read, else write
//   REQ_ADDR, REQ_DATA  request address and write data
//   RSP_VALID/READY     response handshake, RSP_DATA valid with RSP_VALID
//   BRAM_EN/WE/ADDR/DI  drive the BRAM port; BRAM_DO is its read data
//   CREDITS_USED        responses in flight plus responses queued
// Every response-generating request reserves a FIFO slot (a credit) when it is
// accepted, so a response arriving from the BRAM always has room.
module bram_server_port
    import bram_pkg::*;
#(
    parameter int PIPELINED     = 0,
    parameter int ADDR_WIDTH    = 1,
    parameter int DATA_WIDTH    = 1,
    parameter int CHUNKSIZE     = 1,
    parameter int WE_WIDTH      = 1,
    parameter int RESP_DEPTH    = 4,
    parameter int RESP_ON_WRITE = 0
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      REQ_VALID,
    output logic                                      REQ_READY,
    input  logic [WE_WIDTH-1:0]                       REQ_WE,
    input  logic [ADDR_WIDTH-1:0]                     REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]                     REQ_DATA,
    output logic                                      RSP_VALID,
    input  logic                                      RSP_READY,
    output logic [DATA_WIDTH-1:0]                     RSP_DATA,
    output logic                                      BRAM_EN,
    output logic [WE_WIDTH-1:0]                       BRAM_WE,
    output logic [ADDR_WIDTH-1:0]                     BRAM_ADDR,
    output logic [DATA_WIDTH-1:0]                     BRAM_DI,
    input  logic [DATA_WIDTH-1:0]                     BRAM_DO,
    output logic [bram_credit_width(RESP_DEPTH)-1:0]  CREDITS_USED
);

    localparam int L  = bram_latency(PIPELINED);
    localparam int CW = bram_credit_width(RESP_DEPTH);

    if (!bram_widths_ok(DATA_WIDTH, CHUNKSIZE, WE_WIDTH)) begin : g_bad_width
        $error("bram_server_port: DATA_WIDTH must equal CHUNKSIZE*WE_WIDTH");
    end
    if (!bram_depth_ok(RESP_DEPTH)) begin : g_bad_depth
        $error("bram_server_port: RESP_DEPTH must be at least 1");
    end
    if (bram_depth_ok(RESP_DEPTH) && !bram_full_rate(RESP_DEPTH, PIPELINED)) begin : g_slow_depth
        $warning("bram_server_port: RESP_DEPTH below latency+2 limits throughput");
    end

    logic [CW-1:0] credit_cnt;
    logic [L-1:0]  tag_vld_p;     // bit i: response expected, i+1 cycles after accept
    logic          accept;
    logic          rsp_expected;
    logic          rsp_pop;
    logic          fifo_full;
    logic          fifo_empty;

    // Request side: ready comes from registered credit state only.
    assign REQ_READY    = !RST && (credit_cnt < CW'(RESP_DEPTH));
    assign accept       = REQ_VALID && REQ_READY;
    assign BRAM_EN      = accept;
    assign BRAM_WE      = accept ? REQ_WE : '0;
    assign BRAM_ADDR    = REQ_ADDR;
    assign BRAM_DI      = REQ_DATA;
    assign rsp_expected = accept && ((REQ_WE == '0) || (RESP_ON_WRITE != 0));

    assign RSP_VALID    = !fifo_empty;
    assign rsp_pop      = RSP_VALID && RSP_READY;
    assign CREDITS_USED = credit_cnt;

    // Credit counter: a pop frees its slot for the following cycle only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            credit_cnt <= '0;
        end else begin
            case ({rsp_expected, rsp_pop})
                2'b10:   credit_cnt <= credit_cnt + CW'(1);
                2'b01:   credit_cnt <= credit_cnt - CW'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Stage boundary: accept cycle -> tag stages, aligned with BRAM read latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= rsp_expected;
            for (int i = 1; i < L; i++) tag_vld_p[i] <= tag_vld_p[i-1];
        end
    end

    // Stage boundary: last tag stage coincides with BRAM_DO -> FIFO push.
    bram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (tag_vld_p[L-1]),
        .push_data (BRAM_DO),
        .pop       (rsp_pop),
        .pop_data  (RSP_DATA),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    rsp_fifo_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(tag_vld_p[L-1] && fifo_full))
        else $error("bram_server_port: response FIFO overflow");

endmodule
